ex_muldiv_unit: RTL

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64 M-extension multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// followed by a one-cycle sign fix-up. Stalls the pipeline until the result is ready.
module ex_muldiv_unit #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            op_valid_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic            flush_i,
   input  logic            advance_i,
   output logic            muldiv_stall_o,
   output logic            result_valid_o,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned CW = $clog2(XLEN + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic [2:0]        op_q;
   logic              sign_a_q, sign_b_q;
   logic [XLEN-1:0]   mcand_q;       // multiplicand (mul) or divisor (div)
   logic [2*XLEN-1:0] prod_q;        // product accumulator; low half is quotient for div
   logic [XLEN-1:0]   rem_q;
   logic [XLEN-1:0]   result_q;
   logic              result_valid_q;

   logic              is_div, a_signed, b_signed, sign_a, sign_b;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   a_mag, b_mag, special_res;
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0] mul_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

   // Operand decode and special-case detection, used only while IDLE
   always_comb begin
      is_div      = op_i[2];
      a_signed    = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                    (op_i == OP_DIV) || (op_i == OP_REM);
      b_signed    = (op_i == OP_MUL) || (op_i == OP_MULH) ||
                    (op_i == OP_DIV) || (op_i == OP_REM);
      sign_a      = a_signed & rs1_data_i[XLEN-1];
      sign_b      = b_signed & rs2_data_i[XLEN-1];
      a_mag       = sign_a ? -rs1_data_i : rs1_data_i;
      b_mag       = sign_b ? -rs2_data_i : rs2_data_i;
      div_zero    = is_div && (rs2_data_i == '0);
      div_ovf     = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                    (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);
      special     = div_zero || div_ovf;
      special_res = '0;
      if (div_zero) special_res = op_i[1] ? rs1_data_i : '1;
      else if (div_ovf) special_res = op_i[1] ? '0 : rs1_data_i;
   end

   // One radix-2 step for each operation class
   always_comb begin
      mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      div_shift = {rem_q, prod_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, mcand_q};
   end

   // Sign fix-up and result selection applied in FIX
   always_comb begin
      mul_fix = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
      quo_fix = (sign_a_q ^ sign_b_q) ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
      rem_fix = sign_a_q ? -rem_q : rem_q;
      fix_res = '0;
      case (op_q)
         OP_MUL:                       fix_res = mul_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = mul_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fix_res = quo_fix;
         OP_REM, OP_REMU:              fix_res = rem_fix;
         default:                      fix_res = '0;
      endcase
   end

   // Next-state logic; flush overrides every transition
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (op_valid_i) state_d = special ? S_DONE : S_BUSY;
            S_BUSY: if (cnt_q == CW'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (advance_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Datapath: operand capture in IDLE, iteration in BUSY, result capture on entry to DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q          <= '0;
         op_q           <= '0;
         sign_a_q       <= 1'b0;
         sign_b_q       <= 1'b0;
         mcand_q        <= '0;
         prod_q         <= '0;
         rem_q          <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         result_valid_q <= (state_d == S_DONE);
         case (state_q)
            S_IDLE: begin
               if (op_valid_i && !flush_i) begin
                  op_q     <= op_i;
                  sign_a_q <= sign_a;
                  sign_b_q <= sign_b;
                  mcand_q  <= is_div ? b_mag : a_mag;
                  prod_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                  rem_q    <= '0;
                  cnt_q    <= CW'(XLEN);
                  if (special) result_q <= special_res;
               end
            end
            S_BUSY: begin
               cnt_q <= cnt_q - CW'(1);
               if (!op_q[2]) begin
                  prod_q <= {mul_sum, prod_q[XLEN-1:1]};
               end else if (!div_diff[XLEN]) begin
                  rem_q              <= div_diff[XLEN-1:0];
                  prod_q[XLEN-1:0]   <= {prod_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_q              <= div_shift[XLEN-1:0];
                  prod_q[XLEN-1:0]   <= {prod_q[XLEN-2:0], 1'b0};
               end
            end
            S_FIX: begin
               if (state_d == S_DONE) result_q <= fix_res;
            end
            default: ;
         endcase
      end
   end

   // Stall is combinational so it covers the very first EX cycle of the op
   assign muldiv_stall_o = op_valid_i & ~flush_i & (state_q != S_DONE) & ~rst;
   assign result_valid_o = result_valid_q;
   assign result_o       = result_q;

endmodule
